dma_copy_master: RTL
====================

Name: dma_copy_master

Overview:
- Bus initiator that drives the data-memory bus (rd/wr/addr/wdata in, rdata/accessable back) from the master side.
- Copies a block of 32-bit words from a source address to a destination address, one word at a time, without CPU involvement.
- Sits beside the CPU load/store path behind a simple request/grant arbiter.
- Raises a level interrupt on completion or fault.

Parameters:
- LEN_W, 16, width of the word-count register (max transfer 2^LEN_W-1 words).
- ADDR_W, 32, bus address width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches src/dst/len and begins transfer
- src_addr  in  ADDR_W  source byte address, must be word aligned
- dst_addr  in  ADDR_W  destination byte address, must be word aligned
- len  in  LEN_W  number of words to copy
- abort  in  1  stop transfer after current bus cycle
- irq_clr  in  1  clears done/err/irq
- bus_req  out  1  request ownership of data-memory bus
- bus_gnt  in  1  arbiter grant, may drop any cycle
- rd  out  1  bus read strobe
- wr  out  1  bus write strobe
- addr  out  ADDR_W  bus address
- wdata  out  32  bus write data
- rdata  in  32  bus read data, valid combinationally in the cycle rd is high
- accessable  in  1  responder decode ok for current addr; 0 means fault
- busy  out  1  transfer in progress
- done  out  1  sticky, transfer completed normally
- err  out  1  sticky, alignment fault, access fault or abort
- remaining  out  LEN_W  words not yet written
- irq  out  1  done | err

Behaviour:
- Reset (async, reset_n=0): state IDLE; bus_req, rd, wr, busy, done, err, irq = 0; addr, wdata, remaining = 0; internal pointers and buffer cleared.
- Bus timing contract (responder side):
  - A read completes in the cycle rd=1: rdata and accessable are sampled at that rising edge.
  - A write commits at the rising edge where wr=1; accessable is sampled at the same edge.
- Strobe and output rules:
  - rd/wr are never high together.
  - rd/wr are only high when bus_gnt=1; otherwise both are 0 and addr holds its value.
  - addr/wdata are registered outputs.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start with src[1:0]!=0 or dst[1:0]!=0 -> err=1, stay IDLE.
  - start with len=0 -> done=1, stay IDLE.
  - Otherwise: latch pointers and count, remaining=len, busy=1, bus_req=1, go RD.
  - start while busy is ignored.
- RD:
  - Drive rd=1, addr=src_ptr when granted.
  - Edge with gnt&accessable: buffer<=rdata, go WR.
  - Edge with gnt&!accessable: err=1, go FIN.
  - No gnt: hold.
- WR:
  - Drive wr=1, addr=dst_ptr, wdata=buffer when granted.
  - Edge with gnt&accessable: src_ptr+=4, dst_ptr+=4, remaining-=1.
    - remaining was 1 -> done=1, go FIN.
    - else go RD.
  - Edge with gnt&!accessable: err=1, go FIN; remaining unchanged.
- Throughput: 2 cycles per word with continuous grant; first rd high the cycle after start.
- FIN: bus_req=0, busy=0, go IDLE (1 cycle).
- abort:
  - Sampled each edge in RD/WR.
  - Takes effect only at an edge where no bus transfer completes, or after the in-flight WR completes; never splits a granted write.
  - Sets err=1, go FIN.
- Pointer arithmetic: pointers wrap modulo 2^ADDR_W; no boundary check beyond accessable.
- irq = done|err, level.
  - irq_clr clears done and err.
  - irq_clr in the same cycle as a new done/err set: the set wins.
- Reset mid-transfer: immediate return to IDLE; the partially copied destination is left as-is.

Decomposition:
- Shared package: state encoding constants (IDLE/RD/WR/FIN), WORD_BYTES=4, bus address segment constants (0x10010xxx global, 0x7ffffxxx stack, 0x40000xxx peripheral) for benches.
- Single module; no sub-module needed. Arbiter stays external.

Test Plan:
- Copy 4 words, global 0x10010000 -> 0x10010040, gnt tied 1 -> 8 bus cycles alternating rd/wr, done=1 and irq=1 on cycle 10 after start, destination words equal source, remaining=0.
- Toggle bus_gnt low for 3 cycles mid-transfer -> rd/wr=0 while low, addr held, transfer resumes, data correct, total 11 cycles.
- src=0x10010080 (beyond 32-word global region), len=2 -> first RD sees accessable=0, err=1, no wr ever asserted, remaining=2.
- start with src=0x10010002 -> err=1 immediately, busy never asserted; start with len=0 -> done=1, no bus_req.
- abort raised during WR of word 2 of 5 -> word 2 written, err=1, remaining=3, bus_req drops next cycle.
- reset_n low during RD -> all outputs 0 asynchronously; irq_clr after a done -> irq=0; start pulsed while busy -> ignored, original transfer completes unchanged.

Source files
------------

// File: rtl/dma_copy_master_pkg.sv
// Shared state encoding, word size and bus segment map for the DMA copy master.
package dma_copy_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } dma_state_e;

  localparam int WORD_BYTES = 4;

  // Data-memory segment bases as decoded by the system bus.
  localparam logic [31:0] SEG_GLOBAL = 32'h1001_0000;
  localparam logic [31:0] SEG_STACK  = 32'h7fff_f000;
  localparam logic [31:0] SEG_PERIPH = 32'h4000_0000;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dma_copy_master.sv
// Word-at-a-time memory-to-memory copier; one read then one write per word,
// two cycles per word under continuous grant. Level irq on completion or fault.
module dma_copy_master
  import dma_copy_master_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              irq_clr,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  input  logic              accessable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  remaining,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  dma_state_e        state_q;
  logic [ADDR_W-1:0] src_ptr_q, dst_ptr_q, addr_q;
  logic [ADDR_W-1:0] src_ptr_d, dst_ptr_d;
  logic [31:0]       wdata_q;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              bus_req_q, busy_q, done_q, err_q;
  logic              start_ok, last_word;

  assign src_ptr_d   = src_ptr_q + STEP;
  assign dst_ptr_d   = dst_ptr_q + STEP;
  assign remaining_d = remaining_q - LEN_W'(1);
  assign last_word   = (remaining_q == LEN_W'(1));
  assign start_ok    = is_word_aligned(src_addr[1:0]) && is_word_aligned(dst_addr[1:0]);

  // Flag sets are written after the irq_clr clear so a same-edge set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      remaining_q <= '0;
      bus_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (irq_clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!start_ok) begin
              err_q <= 1'b1;
            end else if (len == '0) begin
              done_q      <= 1'b1;
              remaining_q <= '0;
            end else begin
              src_ptr_q   <= src_addr;
              dst_ptr_q   <= dst_addr;
              addr_q      <= src_addr;
              remaining_q <= len;
              busy_q      <= 1'b1;
              bus_req_q   <= 1'b1;
              state_q     <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (bus_gnt) begin
            // A completed read is never discarded; abort is honoured next edge.
            if (accessable) begin
              wdata_q <= rdata;
              addr_q  <= dst_ptr_q;
              state_q <= ST_WR;
            end else begin
              err_q     <= 1'b1;
              bus_req_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= ST_FIN;
            end
          end else if (abort) begin
            err_q     <= 1'b1;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= ST_FIN;
          end
        end
        ST_WR: begin
          if (bus_gnt && accessable) begin
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            if (last_word) begin
              done_q    <= 1'b1;
              bus_req_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= ST_FIN;
            end else if (abort) begin
              err_q     <= 1'b1;
              bus_req_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= ST_FIN;
            end else begin
              addr_q  <= src_ptr_d;
              state_q <= ST_RD;
            end
          end else if (bus_gnt || abort) begin
            err_q     <= 1'b1;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= ST_FIN;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes follow the grant combinationally so a dropped grant never sees a cycle.
  assign rd        = (state_q == ST_RD) && bus_gnt;
  assign wr        = (state_q == ST_WR) && bus_gnt;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign bus_req   = bus_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign remaining = remaining_q;
  assign irq       = done_q | err_q;

endmodule
